ft245_sync_arbiter: RTL and testbench

- Bus controller for the FT2232H in FT245 synchronous FIFO mode, clocked by the 60 MHz FT2232H clock.
- Shares the single bidirectional 8-bit ADBUS between a host→FPGA receive path and an FPGA→host transmit path.
- Sequences OE#/RD#/WR# with the mandatory bus turnaround and bounds each burst so neither direction starves.
- Sits between the top-level pad tristate and two FWFT FIFOs: a TX source and an RX sink.

---
 rtl/ft245_pkg.sv | 20 ++
 rtl/ft245_burst_ctr.sv | 40 ++++
 rtl/ft245_sync_arbiter.sv | 121 ++++++++++++
 tb/tb_ft245_sync_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft245_pkg.sv
// Shared types and constants for the FT245 synchronous FIFO bus arbiter.
// Holds the controller state encoding, the fairness direction tags and default sizing.
package ft245_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RX_OE = 3'd1,
      RX_RD = 3'd2,
      TX_WR = 3'd3,
      TURN  = 3'd4
   } ft245_state_e;

   // Direction tags remembered in last_served; the opposite one wins a tie.
   localparam logic DIR_RX = 1'b0;
   localparam logic DIR_TX = 1'b1;

   localparam int unsigned MAX_BURST_DEF = 512;
   localparam int unsigned BCNT_W_DEF    = 16;

endpackage

// File: rtl/ft245_burst_ctr.sv
// Per-burst byte counter: cleared between bursts, bumped on each transfer,
// flags the cycle whose transfer is the last one a burst may carry.
module ft245_burst_ctr
   import ft245_pkg::*;
#(
   parameter int unsigned MAX_BURST = MAX_BURST_DEF,
   parameter int unsigned BCNT_W    = BCNT_W_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic inc_i,
   output logic tc_o
);

   localparam logic [BCNT_W-1:0] TC_VAL = BCNT_W'(MAX_BURST - 1);

   logic [BCNT_W-1:0] cnt_q;
   logic [BCNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + BCNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/ft245_sync_arbiter.sv
// FT2232H FT245 synchronous-FIFO bus controller: arbitrates the shared ADBUS
// between host->FPGA reads and FPGA->host writes with bounded, alternating bursts.
module ft245_sync_arbiter
   import ft245_pkg::*;
#(
   parameter int unsigned MAX_BURST = MAX_BURST_DEF,
   parameter int unsigned BCNT_W    = BCNT_W_DEF
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic       rxf_n_i,
   input  logic       txe_n_i,
   output logic       rd_n_o,
   output logic       wr_n_o,
   output logic       oe_n_o,
   input  logic [7:0] data_i,
   output logic [7:0] data_o,
   output logic       data_oe_o,
   input  logic [7:0] tx_data_i,
   input  logic       tx_empty_i,
   output logic       tx_rd_o,
   output logic [7:0] rx_data_o,
   input  logic       rx_full_i,
   output logic       rx_wr_o,
   output logic       busy_o
);

   ft245_state_e state_q, state_d;
   logic         last_q, last_d;
   logic         oe_n_q, oe_n_d;
   logic         data_oe_q, data_oe_d;
   logic         busy_q, busy_d;

   logic rx_pend, tx_pend;
   logic rx_xfer, tx_xfer;
   logic cnt_tc;

   assign rx_pend = !rxf_n_i && !rx_full_i;
   assign tx_pend = !txe_n_i && !tx_empty_i;

   // A reset cycle never moves a byte, so nothing is popped or pushed half-way.
   assign rx_xfer = (state_q == RX_RD) && rx_pend && !rst_i;
   assign tx_xfer = (state_q == TX_WR) && tx_pend && !rst_i;

   ft245_burst_ctr #(
      .MAX_BURST (MAX_BURST),
      .BCNT_W    (BCNT_W)
   ) u_burst_ctr (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (state_q == IDLE),
      .inc_i (rx_xfer || tx_xfer),
      .tc_o  (cnt_tc)
   );

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (en_i) begin
               if (rx_pend && (!tx_pend || (last_q == DIR_TX))) begin
                  state_d = RX_OE;
               end else if (tx_pend) begin
                  state_d = TX_WR;
               end
            end
         end
         RX_OE: state_d = RX_RD;
         RX_RD: begin
            if (!rx_pend || !en_i || (rx_xfer && cnt_tc)) begin
               state_d = TURN;
               last_d  = DIR_RX;
            end
         end
         TX_WR: begin
            if (!tx_pend || !en_i || (tx_xfer && cnt_tc)) begin
               state_d = TURN;
               last_d  = DIR_TX;
            end
         end
         TURN:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Bus-direction outputs follow the state being entered, so they are glitch-free flops.
      oe_n_d    = !((state_d == RX_OE) || (state_d == RX_RD));
      data_oe_d = (state_d == TX_WR);
      busy_d    = (state_d != IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         last_q    <= DIR_TX;
         oe_n_q    <= 1'b1;
         data_oe_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         oe_n_q    <= oe_n_d;
         data_oe_q <= data_oe_d;
         busy_q    <= busy_d;
      end
   end

   assign oe_n_o    = oe_n_q;
   assign data_oe_o = data_oe_q;
   assign busy_o    = busy_q;

   // Strobes track the live flags so a flag drop stops the byte in the same cycle.
   assign rd_n_o    = !rx_xfer;
   assign rx_wr_o   = rx_xfer;
   assign wr_n_o    = !tx_xfer;
   assign tx_rd_o   = tx_xfer;
   assign rx_data_o = data_i;
   assign data_o    = tx_data_i;

endmodule

// File: tb/tb_ft245_sync_arbiter.sv
// Directed bench for ft245_sync_arbiter: three instances (default, MAX_BURST=8, MAX_BURST=4)
// share stimulus; sel picks the one whose outputs drive the host/FIFO models and checks.
module tb_ft245_sync_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, en, rxf_n, txe_n, rx_full, tx_empty;
   logic [7:0] data_in, tx_data;

   logic       rd_n_w    [3];
   logic       wr_n_w    [3];
   logic       oe_n_w    [3];
   logic       data_oe_w [3];
   logic       tx_rd_w   [3];
   logic       rx_wr_w   [3];
   logic       busy_w    [3];
   logic [7:0] data_o_w  [3];
   logic [7:0] rx_data_w [3];

   ft245_sync_arbiter u_dut_def (
      .clk_i(clk), .rst_i(rst), .en_i(en), .rxf_n_i(rxf_n), .txe_n_i(txe_n),
      .rd_n_o(rd_n_w[0]), .wr_n_o(wr_n_w[0]), .oe_n_o(oe_n_w[0]),
      .data_i(data_in), .data_o(data_o_w[0]), .data_oe_o(data_oe_w[0]),
      .tx_data_i(tx_data), .tx_empty_i(tx_empty), .tx_rd_o(tx_rd_w[0]),
      .rx_data_o(rx_data_w[0]), .rx_full_i(rx_full), .rx_wr_o(rx_wr_w[0]),
      .busy_o(busy_w[0]));

   ft245_sync_arbiter #(.MAX_BURST(8)) u_dut_b8 (
      .clk_i(clk), .rst_i(rst), .en_i(en), .rxf_n_i(rxf_n), .txe_n_i(txe_n),
      .rd_n_o(rd_n_w[1]), .wr_n_o(wr_n_w[1]), .oe_n_o(oe_n_w[1]),
      .data_i(data_in), .data_o(data_o_w[1]), .data_oe_o(data_oe_w[1]),
      .tx_data_i(tx_data), .tx_empty_i(tx_empty), .tx_rd_o(tx_rd_w[1]),
      .rx_data_o(rx_data_w[1]), .rx_full_i(rx_full), .rx_wr_o(rx_wr_w[1]),
      .busy_o(busy_w[1]));

   ft245_sync_arbiter #(.MAX_BURST(4)) u_dut_b4 (
      .clk_i(clk), .rst_i(rst), .en_i(en), .rxf_n_i(rxf_n), .txe_n_i(txe_n),
      .rd_n_o(rd_n_w[2]), .wr_n_o(wr_n_w[2]), .oe_n_o(oe_n_w[2]),
      .data_i(data_in), .data_o(data_o_w[2]), .data_oe_o(data_oe_w[2]),
      .tx_data_i(tx_data), .tx_empty_i(tx_empty), .tx_rd_o(tx_rd_w[2]),
      .rx_data_o(rx_data_w[2]), .rx_full_i(rx_full), .rx_wr_o(rx_wr_w[2]),
      .busy_o(busy_w[2]));

   int checks = 0;
   int errors = 0;
   int sel;
   int cyc;
   int last_oe, last_drv;
   logic prev_doe, prev_oe_n;

   logic       o_rd_n, o_wr_n, o_oe_n, o_doe, o_tx_rd, o_rx_wr, o_busy;
   logic [7:0] o_data, o_rx_data;

   logic [7:0] host_q [$];
   logic [7:0] tx_q   [$];
   logic [7:0] rx_log [$];
   logic [7:0] tx_log [$];
   int         rx_cyc [$];
   int         tx_cyc [$];
   bit         host_on;

   logic busy_h [64];
   logic doe_h  [64];

   logic [3:0] e;
   int tx_req_cyc [10] = '{1, 2, 3, 4, 7, 8, 9, 10, 13, 14};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, req);
      end
   endtask

   task automatic apply_inputs();
      rxf_n    = host_on ? (host_q.size() == 0) : 1'b1;
      data_in  = (host_q.size() > 0) ? host_q[0] : 8'h00;
      tx_empty = (tx_q.size() == 0);
      tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
   endtask

   // Sample the current cycle on the falling edge, then step past the rising edge.
   task automatic tick();
      @(negedge clk);
      o_rd_n    = rd_n_w[sel];
      o_wr_n    = wr_n_w[sel];
      o_oe_n    = oe_n_w[sel];
      o_doe     = data_oe_w[sel];
      o_tx_rd   = tx_rd_w[sel];
      o_rx_wr   = rx_wr_w[sel];
      o_busy    = busy_w[sel];
      o_data    = data_o_w[sel];
      o_rx_data = rx_data_w[sel];
      if (cyc < 64) begin
         busy_h[cyc] = o_busy;
         doe_h[cyc]  = o_doe;
      end
      chk("bus_exclusive", {31'd0, (!o_oe_n && o_doe)}, 32'd0);
      if (o_doe && !prev_doe)
         chk("gap_oe_to_drive", ((cyc - last_oe) >= 3) ? 32'd1 : 32'd0, 32'd1);
      if (!o_oe_n && prev_oe_n)
         chk("gap_drive_to_oe", ((cyc - last_drv) >= 3) ? 32'd1 : 32'd0, 32'd1);
      if (!o_oe_n) last_oe = cyc;
      if (o_doe) last_drv = cyc;
      prev_doe  = o_doe;
      prev_oe_n = o_oe_n;
      if (o_rx_wr) begin
         rx_log.push_back(o_rx_data);
         rx_cyc.push_back(cyc);
      end
      if (o_tx_rd) begin
         tx_log.push_back(o_data);
         tx_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (o_rx_wr && host_q.size() > 0) void'(host_q.pop_front());
      if (o_tx_rd && tx_q.size() > 0) void'(tx_q.pop_front());
      apply_inputs();
   endtask

   task automatic reset_all(input int s);
      sel     = s;
      host_on = 1'b0;
      txe_n   = 1'b1;
      rx_full = 1'b0;
      en      = 1'b1;
      rst     = 1'b1;
      host_q.delete();
      tx_q.delete();
      apply_inputs();
      @(posedge clk);
      #1;
      prev_doe  = 1'b0;
      prev_oe_n = 1'b1;
      last_oe   = -100;
      last_drv  = -100;
      tick();
      tick();
      rst = 1'b0;
      cyc = 0;
      rx_log.delete();
      tx_log.delete();
      rx_cyc.delete();
      tx_cyc.delete();
   endtask

   initial begin
      // Reset then idle: every output holds its reset value.
      reset_all(0);
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("idle_outputs", {25'd0, o_rd_n, o_wr_n, o_oe_n, o_doe, o_tx_rd, o_rx_wr, o_busy},
             32'b1110000);
      end

      // Enable low: host data pending but no burst starts.
      en = 1'b0;
      host_q.push_back(8'h55);
      host_on = 1'b1;
      apply_inputs();
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("en_low_idle", {30'd0, o_busy, o_rd_n}, 32'b01);
      end

      // RX-only stream of 0x00..0x09.
      reset_all(0);
      for (int i = 0; i < 10; i++) host_q.push_back(8'(i));
      host_on = 1'b1;
      apply_inputs();
      for (int k = 0; k < 16; k++) begin
         tick();
         if (k == 0)       e = 4'b0110;
         else if (k == 1)  e = 4'b1010;
         else if (k <= 11) e = 4'b1001;
         else if (k == 12) e = 4'b1010;
         else if (k == 13) e = 4'b1110;
         else              e = 4'b0110;
         chk("rx_stream_ctl", {28'd0, o_busy, o_oe_n, o_rd_n, o_rx_wr}, {28'd0, e});
         chk("rx_stream_doe", {31'd0, o_doe}, 32'd0);
         if (k >= 2 && k <= 11) chk("rx_stream_data", {24'd0, o_rx_data}, 32'(k - 2));
      end

      // TX burst limit with MAX_BURST=4 and 10 queued bytes: 4, 4, 2.
      reset_all(2);
      for (int i = 0; i < 10; i++) tx_q.push_back(8'(8'hA0 + i));
      txe_n = 1'b0;
      apply_inputs();
      for (int k = 0; k < 20; k++) tick();
      chk("tx_limit_count", 32'(tx_log.size()), 32'd10);
      for (int i = 0; i < 10 && i < tx_log.size(); i++) begin
         chk("tx_limit_cycle", 32'(tx_cyc[i]), 32'(tx_req_cyc[i]));
         chk("tx_limit_data", {24'd0, tx_log[i]}, 32'(8'hA0 + i));
      end
      chk("tx_turn1", {30'd0, doe_h[5], doe_h[6]}, 32'd0);
      chk("tx_turn2", {30'd0, doe_h[11], doe_h[12]}, 32'd0);
      chk("tx_empty_exit", {30'd0, doe_h[15], doe_h[16]}, 32'b10);
      chk("tx_final_idle", {31'd0, busy_h[17]}, 32'd0);

      // Contention fairness with MAX_BURST=8: RX, TX, RX, TX.
      reset_all(1);
      for (int i = 0; i < 40; i++) begin
         host_q.push_back(8'(i));
         tx_q.push_back(8'(8'h80 + i));
      end
      host_on = 1'b1;
      txe_n   = 1'b0;
      apply_inputs();
      for (int k = 0; k < 43; k++) tick();
      chk("fair_rx_count", 32'(rx_log.size()), 32'd16);
      chk("fair_tx_count", 32'(tx_log.size()), 32'd16);
      if (rx_cyc.size() >= 16 && tx_cyc.size() >= 16) begin
         chk("fair_rx1_start", 32'(rx_cyc[0]), 32'd2);
         chk("fair_rx1_end", 32'(rx_cyc[7]), 32'd9);
         chk("fair_tx1_start", 32'(tx_cyc[0]), 32'd12);
         chk("fair_tx1_end", 32'(tx_cyc[7]), 32'd19);
         chk("fair_rx2_start", 32'(rx_cyc[8]), 32'd23);
         chk("fair_tx2_start", 32'(tx_cyc[8]), 32'd33);
         chk("fair_rx_data", {24'd0, rx_log[15]}, 32'd15);
         chk("fair_tx_data", {24'd0, tx_log[15]}, 32'h8F);
      end

      // Backpressure: RX FIFO full for one cycle mid-burst.
      reset_all(0);
      for (int i = 0; i < 16; i++) host_q.push_back(8'(8'h10 + i));
      host_on = 1'b1;
      apply_inputs();
      for (int k = 0; k < 7; k++) tick();
      rx_full = 1'b1;
      tick();
      chk("bp_stall", {30'd0, o_rd_n, o_rx_wr}, 32'b10);
      rx_full = 1'b0;
      tick();
      chk("bp_turn", {30'd0, o_busy, o_oe_n}, 32'b11);
      tick();
      chk("bp_idle", {31'd0, o_busy}, 32'd0);
      tick();
      chk("bp_rx_oe", {29'd0, o_oe_n, o_rd_n, o_busy}, 32'b011);
      for (int k = 0; k < 15; k++) tick();
      chk("bp_count", 32'(rx_log.size()), 32'd16);
      for (int i = 0; i < 16 && i < rx_log.size(); i++)
         chk("bp_data", {24'd0, rx_log[i]}, 32'(8'h10 + i));
      chk("bp_end", {30'd0, busy_h[23], busy_h[24]}, 32'b10);

      // Reset during the third byte of a TX burst.
      reset_all(2);
      for (int i = 0; i < 10; i++) tx_q.push_back(8'(8'hB0 + i));
      txe_n = 1'b0;
      apply_inputs();
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("rst_no_pop", {30'd0, o_wr_n, o_tx_rd}, 32'b10);
      rst   = 1'b0;
      txe_n = 1'b1;
      apply_inputs();
      tick();
      chk("rst_after_edge", {29'd0, o_wr_n, o_doe, o_busy}, 32'b100);
      tick();
      tick();
      chk("rst_pop_count", 32'(tx_log.size()), 32'd2);
      if (tx_log.size() >= 2) begin
         chk("rst_byte0", {24'd0, tx_log[0]}, 32'hB0);
         chk("rst_byte1", {24'd0, tx_log[1]}, 32'hB1);
      end
      chk("rst_fifo_left", 32'(tx_q.size()), 32'd8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
